// File: rtl/memaccess_unit.sv
// LC3 data-memory access stage: runs LD/LDR/LDI/ST/STR/STI sequences against a
// variable-latency req/ack memory, with a watchdog that aborts a stuck access.
module memaccess_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] IR_Exec,
  input  logic [15:0] mem_addr,
  input  logic [15:0] M_Data,
  input  logic [15:0] dmem_dout,
  input  logic        dmem_ack,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_din,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic [15:0] memout,
  output logic        complete_data,
  output logic [1:0]  mem_state,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IND,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [3:0]  OP_LD    = 4'b0010;
  localparam logic [3:0]  OP_LDR   = 4'b0110;
  localparam logic [3:0]  OP_LDI   = 4'b1010;
  localparam logic [3:0]  OP_STI   = 4'b1011;
  localparam logic [3:0]  OP_ST    = 4'b0011;
  localparam logic [3:0]  OP_STR   = 4'b0111;
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);
  localparam bit          WD_EN    = (TIMEOUT != 0);

  state_t      state_reg, state_next;
  logic [15:0] addr_reg, addr_next;
  logic [15:0] data_reg, data_next;
  logic [15:0] memout_reg, memout_next;
  logic [15:0] wd_reg, wd_next;
  logic [3:0]  op_reg, op_next;
  logic        err_reg, err_next;
  logic        in_access;
  logic        wd_expired;

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    data_next   = data_reg;
    memout_next = memout_reg;
    op_next     = op_reg;
    err_next    = err_reg;
    wd_next     = 16'h0000;
    in_access   = (state_reg == S_IND) || (state_reg == S_READ) || (state_reg == S_WRITE);
    wd_expired  = WD_EN && (wd_reg == WD_LIMIT);

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          case (IR_Exec[15:12])
            OP_LD, OP_LDR:  state_next = S_READ;
            OP_LDI, OP_STI: state_next = S_IND;
            OP_ST, OP_STR:  state_next = S_WRITE;
            default:        state_next = S_IDLE;
          endcase
          // Non-memory opcodes leave every register, including err, untouched.
          if (state_next != S_IDLE) begin
            addr_next = mem_addr;
            data_next = M_Data;
            op_next   = IR_Exec[15:12];
            err_next  = 1'b0;
          end
        end
      end
      S_IND: begin
        if (dmem_ack) begin
          addr_next  = dmem_dout;
          state_next = (op_reg == OP_LDI) ? S_READ : S_WRITE;
        end
      end
      S_READ: begin
        if (dmem_ack) begin
          memout_next = dmem_dout;
          state_next  = S_DONE;
        end
      end
      S_WRITE: begin
        if (dmem_ack) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    // An ack in the expiry cycle takes priority, so only the no-ack path can abort.
    if (in_access && !dmem_ack) begin
      if (wd_expired) begin
        state_next = S_DONE;
        err_next   = 1'b1;
      end else begin
        wd_next = wd_reg + 16'h0001;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      addr_reg   <= 16'h0000;
      data_reg   <= 16'h0000;
      memout_reg <= 16'h0000;
      wd_reg     <= 16'h0000;
      op_reg     <= 4'h0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
      memout_reg <= memout_next;
      wd_reg     <= wd_next;
      op_reg     <= op_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    case (state_reg)
      S_IND:   mem_state = 2'd1;
      S_READ:  mem_state = 2'd0;
      S_WRITE: mem_state = 2'd2;
      default: mem_state = 2'd3;
    endcase
  end

  assign dmem_addr     = addr_reg;
  assign dmem_din      = data_reg;
  assign dmem_rd       = (state_reg == S_IND) || (state_reg == S_READ);
  assign dmem_wr       = (state_reg == S_WRITE);
  assign memout        = memout_reg;
  assign complete_data = (state_reg == S_DONE);
  assign busy          = (state_reg != S_IDLE);
  assign err           = err_reg;

endmodule

// File: tb/tb_memaccess_unit.sv
// Bench for memaccess_unit: a behavioural memory responder with programmable
// ack latency, plus a sequence-level reference model of each LC3 memory opcode.
module tb_memaccess_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic [15:0] mem_addr = 16'h0000;
  logic [15:0] m_data = 16'h0000;
  logic [15:0] dmem_dout = 16'h0000;
  logic        dmem_ack = 1'b0;
  logic [15:0] dmem_addr, dmem_din, memout;
  logic        dmem_rd, dmem_wr, complete_data, busy, err;
  logic [1:0]  mem_state;

  memaccess_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .IR_Exec(ir), .mem_addr(mem_addr),
    .M_Data(m_data), .dmem_dout(dmem_dout), .dmem_ack(dmem_ack),
    .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .memout(memout), .complete_data(complete_data), .mem_state(mem_state),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  int          lat = 0;
  bit          noack = 1'b0;
  logic [15:0] q_addr[$];
  logic [15:0] q_data[$];
  bit          q_wr[$];
  int          n_total = 0;
  int          n_bad = 0;
  logic [15:0] exp_memout = 16'h0000;
  logic        exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks after `lat` waiting cycles, logs every real ack,
  // and throws random acks/data at the DUT whenever no request is pending.
  initial begin : responder
    int cnt;
    bit real_ack;
    cnt = 0;
    real_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (real_ack) cnt = 0;
      real_ack = 1'b0;
      if (rst && (dmem_rd || dmem_wr)) begin
        if (!noack && cnt >= lat) begin
          dmem_ack = 1'b1;
          real_ack = 1'b1;
          if (dmem_wr) begin
            mem[dmem_addr] = dmem_din;
            q_data.push_back(dmem_din);
          end else begin
            dmem_dout = mem[dmem_addr];
            q_data.push_back(dmem_dout);
          end
          q_addr.push_back(dmem_addr);
          q_wr.push_back(dmem_wr);
        end else begin
          dmem_ack  = 1'b0;
          dmem_dout = 16'($urandom);
          cnt++;
        end
      end else begin
        dmem_ack  = rst && ($urandom_range(0, 3) == 0);
        dmem_dout = 16'($urandom);
        cnt = 0;
      end
    end
  end

  // Called just after a negedge with the DUT idle.
  task automatic run_seq(input logic [15:0] i_ir, input logic [15:0] i_addr,
                         input logic [15:0] i_data, input int i_lat,
                         input bit i_noack, input bit i_restart);
    logic [3:0]  op;
    bit          is_mem;
    int          n_acc;
    int          n_rd;
    bit          kind_wr [2];
    logic [15:0] ea [2];
    logic [15:0] ed [2];
    bit          tout;
    int          exp_edges, exp_rdc, exp_wrc, exp_nacks;
    logic [15:0] exp_trace, trace;
    logic [1:0]  last;
    int          done_e, pulses, rdc, wrc, activity;

    op = i_ir[15:12];
    is_mem = 1'b1;
    n_acc = 1;
    kind_wr[0] = 1'b0;
    kind_wr[1] = 1'b0;
    case (op)
      4'h2, 4'h6: begin n_acc = 1; kind_wr[0] = 1'b0; end
      4'hA:       begin n_acc = 2; kind_wr[0] = 1'b0; kind_wr[1] = 1'b0; end
      4'hB:       begin n_acc = 2; kind_wr[0] = 1'b0; kind_wr[1] = 1'b1; end
      4'h3, 4'h7: begin n_acc = 1; kind_wr[0] = 1'b1; end
      default:    is_mem = 1'b0;
    endcase

    lat = i_lat;
    noack = i_noack;
    q_addr.delete();
    q_data.delete();
    q_wr.delete();
    ir = i_ir;
    mem_addr = i_addr;
    m_data = i_data;
    start = 1'b1;

    if (!is_mem) begin
      activity = 0;
      for (int e = 0; e < 4; e++) begin
        @(negedge clk);
        if (e == 0) start = 1'b0;
        if (busy || dmem_rd || dmem_wr || complete_data) activity++;
      end
      check("nonmem_activity", activity, 0);
      check("nonmem_err", err, exp_err);
      check("nonmem_memout", memout, exp_memout);
      $display("seq op=%h addr=%h: non-memory opcode, ignored", op, i_addr);
      return;
    end

    // Reference outcome of the sequence, from the current memory contents.
    tout = i_noack || (i_lat > TO);
    ea[0] = i_addr;
    ea[1] = mem[i_addr];
    ed[0] = kind_wr[0] ? i_data : mem[ea[0]];
    ed[1] = kind_wr[1] ? i_data : mem[ea[1]];
    n_rd = 0;
    for (int i = 0; i < n_acc; i++) if (!kind_wr[i]) n_rd++;
    exp_trace = (n_acc == 2) ? 16'd1 : (kind_wr[0] ? 16'd2 : 16'd0);
    if (tout) begin
      exp_edges = TO + 1;
      exp_rdc   = kind_wr[0] ? 0 : TO + 1;
      exp_wrc   = kind_wr[0] ? TO + 1 : 0;
      exp_nacks = 0;
      exp_err   = 1'b1;
    end else begin
      if (n_acc == 2) exp_trace = (exp_trace << 2) | (kind_wr[1] ? 16'd2 : 16'd0);
      exp_edges = n_acc * (i_lat + 1);
      exp_rdc   = n_rd * (i_lat + 1);
      exp_wrc   = (n_acc - n_rd) * (i_lat + 1);
      exp_nacks = n_acc;
      exp_err   = 1'b0;
      if (!kind_wr[n_acc-1]) exp_memout = ed[n_acc-1];
    end
    exp_trace = (exp_trace << 2) | 16'd3;

    done_e = -1;
    pulses = 0;
    rdc = 0;
    wrc = 0;
    trace = 16'h0000;
    last = 2'd3;
    for (int e = 0; e < 60; e++) begin
      @(negedge clk);
      if (e == 0) start = 1'b0;
      if (i_restart && e == 1) begin
        start = 1'b1;
        ir = 16'h3000;
        mem_addr = ~i_addr;
        m_data = ~i_data;
      end
      if (i_restart && e == 2) start = 1'b0;
      if (dmem_rd) rdc++;
      if (dmem_wr) wrc++;
      if (mem_state != last) begin
        trace = (trace << 2) | 16'(mem_state);
        last = mem_state;
      end
      if (complete_data) begin
        pulses++;
        if (done_e < 0) done_e = e;
      end
      if (done_e >= 0 && !busy) break;
    end

    check("latency", done_e, exp_edges);
    check("pulses", pulses, 1);
    check("rd_cycles", rdc, exp_rdc);
    check("wr_cycles", wrc, exp_wrc);
    check("state_trace", trace, exp_trace);
    check("memout", memout, exp_memout);
    check("err", err, exp_err);
    check("n_acks", q_addr.size(), exp_nacks);
    for (int i = 0; i < exp_nacks && i < q_addr.size(); i++) begin
      check("acc_addr", q_addr[i], ea[i]);
      check("acc_kind", q_wr[i], kind_wr[i]);
      check("acc_data", q_data[i], ed[i]);
    end
    $display("seq op=%h addr=%h data=%h lat=%0d noack=%0d: done after %0d edges, memout=%h err=%0d",
             op, i_addr, i_data, i_lat, i_noack, done_e, memout, err);
  endtask

  initial begin : main
    int pulses;
    logic [3:0] ops [8];
    ops[0] = 4'h2; ops[1] = 4'h6; ops[2] = 4'hA; ops[3] = 4'hB;
    ops[4] = 4'h3; ops[5] = 4'h7; ops[6] = 4'h1; ops[7] = 4'h5;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

    repeat (2) @(negedge clk);
    check("rst_mem_state", mem_state, 2'd3);
    check("rst_rd", dmem_rd, 1'b0);
    check("rst_wr", dmem_wr, 1'b0);
    check("rst_addr", dmem_addr, 16'h0000);
    check("rst_din", dmem_din, 16'h0000);
    check("rst_memout", memout, 16'h0000);
    check("rst_complete", complete_data, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    mem[16'h3000] = 16'hBEEF;
    run_seq(16'h2000, 16'h3000, 16'h0000, 0, 1'b0, 1'b0);
    check("ld_memout_beef", memout, 16'hBEEF);

    mem[16'h3010] = 16'h4000;
    run_seq(16'hB000, 16'h3010, 16'h1234, 2, 1'b0, 1'b0);
    check("sti_mem_4000", mem[16'h4000], 16'h1234);

    mem[16'h3020] = 16'h5000;
    mem[16'h5000] = 16'h00AA;
    run_seq(16'hA000, 16'h3020, 16'h0000, 1, 1'b0, 1'b0);
    check("ldi_memout_00aa", memout, 16'h00AA);

    run_seq(16'h2000, 16'h3030, 16'h0000, 0, 1'b1, 1'b0);
    check("wd_err_set", err, 1'b1);
    run_seq(16'h6000, 16'h3040, 16'h0000, TO, 1'b0, 1'b0);
    check("wd_err_cleared", err, 1'b0);

    run_seq(16'h1000, 16'h3050, 16'h0000, 0, 1'b0, 1'b0);
    run_seq(16'hA000, 16'h3020, 16'h0000, 1, 1'b0, 1'b1);

    // Reset while a write is waiting for its ack.
    noack = 1'b1;
    ir = 16'h3000;
    mem_addr = 16'h3060;
    m_data = 16'h5A5A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_wr", dmem_wr, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_wr", dmem_wr, 1'b0);
    check("mid_rst_state", mem_state, 2'd3);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_memout", memout, 16'h0000);
    ir = 16'h2000;
    start = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (complete_data || busy) pulses++;
    end
    check("rst_start_ignored", pulses, 0);
    start = 1'b0;
    rst = 1'b1;
    noack = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_err", err, 1'b0);
    exp_memout = 16'h0000;
    exp_err = 1'b0;
    $display("seq reset during WRITE: requests dropped, no completion");

    for (int n = 0; n < 40; n++) begin
      run_seq({ops[$urandom_range(0, 7)], 12'($urandom)}, 16'($urandom), 16'($urandom),
              $urandom_range(0, 6), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
